// File: rtl/fft_run_ctrl.sv
// fft_run_ctrl: run sequencer for one FFT job plus arbitration of the shared sample SRAM.
//   clk, i_resetn (async, active-low)
//   i_start/i_cfg          : job request and point code (N = 2^(cfg+3))
//   i_host_req/o_host_grant: host SRAM access, granted only in IDLE and DONE
//   i_fft_done, i_sram_read_register : stage controller status and bank pointer
//   i_done_ack/o_done      : completion handshake
//   o_engine_resetn, o_point_configuration, o_working, o_cycle_count : engine control
//   o_busy, o_result_bank, o_error : job status
module fft_run_ctrl #(
    parameter int DELAY  = 10,
    parameter int MARGIN = 16,
    parameter int DRAIN  = 12
) (
    input  logic        clk,
    input  logic        i_resetn,
    input  logic        i_start,
    input  logic [2:0]  i_cfg,
    input  logic        i_host_req,
    input  logic        i_fft_done,
    input  logic        i_sram_read_register,
    input  logic        i_done_ack,
    output logic        o_engine_resetn,
    output logic [2:0]  o_point_configuration,
    output logic        o_working,
    output logic [10:0] o_cycle_count,
    output logic        o_busy,
    output logic        o_host_grant,
    output logic        o_done,
    output logic        o_result_bank,
    output logic        o_error
);
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  cfg_q, cfg_d;
    logic [10:0] cc_q, cc_d;
    logic        bank_q, bank_d;
    logic        err_q, err_d;
    logic        eng_rstn_q, eng_rstn_d;
    logic        work_q, work_d;
    logic        done_q, done_d;
    logic [31:0] stages_w, per_stage_w, budget_w;
    logic [11:0] cnt_inc;

    // stages * (butterfly cycles per stage + pipeline latency) + slack, wide then saturated
    assign stages_w    = 32'(i_cfg) + 32'd3;
    assign per_stage_w = (32'd1 << i_cfg) + 32'(DELAY);
    assign budget_w    = stages_w * per_stage_w + 32'(MARGIN);
    assign cnt_inc     = cnt_q + 12'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        cc_d    = cc_q;
        bank_d  = bank_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                // host wins a same-cycle collision; start must be re-asserted
                if (i_start && !i_host_req) begin
                    cfg_d   = i_cfg;
                    cc_d    = (budget_w > 32'd2047) ? 11'd2047 : budget_w[10:0];
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                cnt_d   = (cnt_q == 12'd1) ? '0 : cnt_inc;
                state_d = (cnt_q == 12'd1) ? S_RUN : S_CLR;
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (i_fft_done) begin
                    bank_d  = i_sram_read_register;
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else if (cnt_inc == {cc_q, 1'b0}) begin
                    // watchdog: twice the budget without done
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d   = (cnt_q == 12'(DRAIN - 1)) ? '0 : cnt_inc;
                state_d = (cnt_q == 12'(DRAIN - 1)) ? S_DONE : S_DRAIN;
            end
            S_DONE: state_d = i_done_ack ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
        // registered outputs track the next state so they align with it
        eng_rstn_d = (state_d != S_CLR);
        work_d     = (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cfg_q      <= '0;
            cc_q       <= '0;
            bank_q     <= 1'b0;
            err_q      <= 1'b0;
            eng_rstn_q <= 1'b0;
            work_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cfg_q      <= cfg_d;
            cc_q       <= cc_d;
            bank_q     <= bank_d;
            err_q      <= err_d;
            eng_rstn_q <= eng_rstn_d;
            work_q     <= work_d;
            done_q     <= done_d;
        end
    end

    assign o_engine_resetn       = eng_rstn_q;
    assign o_point_configuration = cfg_q;
    assign o_working             = work_q;
    assign o_cycle_count         = cc_q;
    assign o_busy                = (state_q != S_IDLE);
    assign o_host_grant          = i_host_req && (state_q == S_IDLE || state_q == S_DONE);
    assign o_done                = done_q;
    assign o_result_bank         = bank_q;
    assign o_error               = err_q;
endmodule

// File: tb/tb_fft_run_ctrl.sv
// tb_fft_run_ctrl: directed self-checking bench for fft_run_ctrl.
module tb_fft_run_ctrl;
    logic        clk = 1'b0;
    logic        i_resetn = 1'b0;
    logic        i_start = 1'b0;
    logic [2:0]  i_cfg = '0;
    logic        i_host_req = 1'b0;
    logic        i_fft_done = 1'b0;
    logic        i_sram_read_register = 1'b0;
    logic        i_done_ack = 1'b0;
    logic        o_engine_resetn;
    logic [2:0]  o_point_configuration;
    logic        o_working;
    logic [10:0] o_cycle_count;
    logic        o_busy;
    logic        o_host_grant;
    logic        o_done;
    logic        o_result_bank;
    logic        o_error;
    int          n_chk = 0;
    int          n_pass = 0;

    fft_run_ctrl dut (
        .clk(clk), .i_resetn(i_resetn), .i_start(i_start), .i_cfg(i_cfg),
        .i_host_req(i_host_req), .i_fft_done(i_fft_done),
        .i_sram_read_register(i_sram_read_register), .i_done_ack(i_done_ack),
        .o_engine_resetn(o_engine_resetn), .o_point_configuration(o_point_configuration),
        .o_working(o_working), .o_cycle_count(o_cycle_count), .o_busy(o_busy),
        .o_host_grant(o_host_grant), .o_done(o_done), .o_result_bank(o_result_bank),
        .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input logic [2:0] cfg);
        i_cfg   = cfg;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        i_cfg   = ~cfg;
    endtask

    initial begin
        #2;
        check("rst_engine_resetn", o_engine_resetn, 0);
        check("rst_working", o_working, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_cycle_count", o_cycle_count, 0);
        check("rst_grant", o_host_grant, 0);
        check("rst_busy", o_busy, 0);
        #10 i_resetn = 1'b1;
        tick(1);
        check("idle_engine_resetn", o_engine_resetn, 1);

        // job with cfg=3: budget 6*(8+10)+16 = 124
        start_job(3'd3);
        check("t1_cycle_count", o_cycle_count, 124);
        check("t1_cfg_latched", o_point_configuration, 3);
        check("t1_clr_cycle0", o_engine_resetn, 0);
        check("t1_busy", o_busy, 1);
        tick(1);
        check("t1_clr_cycle1", o_engine_resetn, 0);
        tick(1);
        check("t1_clr_released", o_engine_resetn, 1);
        check("t1_working", o_working, 1);
        i_host_req = 1'b1;
        i_start    = 1'b1;
        tick(60);
        check("t1_grant_in_run", o_host_grant, 0);
        check("t1_still_working", o_working, 1);
        check("t1_cfg_stable", o_point_configuration, 3);
        i_host_req = 1'b0;
        i_start    = 1'b0;
        i_sram_read_register = 1'b1;
        i_fft_done = 1'b1;
        tick(1);
        i_fft_done = 1'b0;
        check("t1_working_off", o_working, 0);
        check("t1_bank", o_result_bank, 1);
        for (int i = 0; i < 11; i++) begin
            i_sram_read_register = ~i_sram_read_register;
            tick(1);
        end
        check("t1_no_early_done", o_done, 0);
        tick(1);
        check("t1_done_after_drain", o_done, 1);
        check("t4_bank_held", o_result_bank, 1);
        i_sram_read_register = 1'b0;
        i_host_req = 1'b1;
        #1 check("t1_grant_in_done", o_host_grant, 1);
        i_host_req = 1'b0;
        tick(3);
        check("t1_done_held", o_done, 1);
        i_done_ack = 1'b1;
        tick(1);
        i_done_ack = 1'b0;
        check("t1_done_cleared", o_done, 0);
        check("t1_idle", o_busy, 0);

        // start colliding with host request: host wins
        i_cfg = 3'd0;
        i_start = 1'b1;
        i_host_req = 1'b1;
        #1 check("t2_grant", o_host_grant, 1);
        tick(1);
        check("t2_start_ignored", o_busy, 0);
        i_host_req = 1'b0;
        tick(1);
        i_start = 1'b0;
        check("t2_start_accepted", o_busy, 1);
        check("t3_cycle_count", o_cycle_count, 49);

        // watchdog with cfg=0: 98 RUN cycles without done
        tick(2);
        check("t3_run", o_working, 1);
        tick(97);
        check("t3_no_early_error", o_error, 0);
        check("t3_still_running", o_working, 1);
        tick(1);
        check("t3_error", o_error, 1);
        check("t3_working_off", o_working, 0);
        tick(11);
        check("t3_no_early_done", o_done, 0);
        tick(1);
        check("t3_done", o_done, 1);
        check("t3_bank_unchanged", o_result_bank, 1);
        i_done_ack = 1'b1;
        tick(1);
        i_done_ack = 1'b0;
        check("t3_error_sticky", o_error, 1);
        start_job(3'd2);
        check("t3_error_cleared", o_error, 0);

        // async reset in RUN, then a fresh job with cfg=1: 4*(2+10)+16 = 64
        tick(5);
        check("t5_in_run", o_working, 1);
        #2 i_resetn = 1'b0;
        #1;
        check("t5_working", o_working, 0);
        check("t5_engine_resetn", o_engine_resetn, 0);
        check("t5_busy", o_busy, 0);
        check("t5_cycle_count", o_cycle_count, 0);
        check("t5_cfg", o_point_configuration, 0);
        check("t5_bank", o_result_bank, 0);
        check("t5_done", o_done, 0);
        #1 i_resetn = 1'b1;
        tick(1);
        start_job(3'd1);
        check("t5_cycle_count_new", o_cycle_count, 64);
        tick(2);
        check("t5_run_new", o_working, 1);
        i_fft_done = 1'b1;
        tick(1);
        i_fft_done = 1'b0;
        tick(12);
        check("t5_done_new", o_done, 1);
        check("t5_error_new", o_error, 0);
        i_done_ack = 1'b1;
        tick(1);
        i_done_ack = 1'b0;

        // cfg=7 budget and ack already high on DONE entry
        start_job(3'd7);
        check("t6_cycle_count", o_cycle_count, 1396);
        tick(2);
        i_fft_done = 1'b1;
        i_sram_read_register = 1'b0;
        tick(1);
        i_fft_done = 1'b0;
        check("t6_bank", o_result_bank, 0);
        i_done_ack = 1'b1;
        tick(12);
        check("t6_done_one_cycle", o_done, 1);
        tick(1);
        check("t6_done_fell", o_done, 0);
        check("t6_idle", o_busy, 0);
        i_done_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
